// File: rtl/spi_block_ctrl.sv
// spi_block_ctrl: memory-mapped SPI master (mode 0) moving BLEN-word blocks between CPU and device via TX/RX FIFOs.
// Latency: register writes take effect on the next clk edge; each word takes 2*CLK_DIV*DATA_W clk plus one load cycle.
// Backpressure: a write block stalls with CS held while TX is empty; a read block stalls while RX is full.
// Ports: clk/reset (sync, active-high); addr/we/re/wdata/rdata processor bus (rdata combinational);
//        sclk/mosi/miso/cs_n SPI pins (cs_n active low, one per chip).

module spi_block_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

module spi_block_ctrl #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int NUM_CS     = 2,
   parameter int BLEN_W     = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        addr,
   input  logic              we,
   input  logic              re,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FLG_W = 5 + 2 * CNT_W;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, DONE} state_t;

   state_t            state, state_n;
   logic              mode, mode_n;            // 0 = write block, 1 = read block
   logic [CS_W-1:0]   chip, chip_n;
   logic [BLEN_W-1:0] wcount, wcount_n;
   logic [DATA_W-1:0] shifter, shifter_n;
   logic [DATA_W-1:0] rx_shift, rx_shift_n;
   logic [BIT_W-1:0]  bit_cnt, bit_n;
   logic [DIV_W-1:0]  div_cnt, div_n;
   logic              sclk_n;
   logic              tx_pop, rx_push;

   logic [BLEN_W-1:0] blen;
   logic              tx_ovf, rx_udf, cmd_err;
   logic              busy, div_last, cs_act;

   logic [DATA_W-1:0] tx_head, rx_head;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic [CNT_W-1:0]  tx_count, rx_count;
   logic [FLG_W-1:0]  flags;

   logic              tx_push, rx_pop, cmd_wr, flags_wr, blen_wr;
   logic [1:0]        cmd;

   assign tx_push  = we && (addr == 3'd0);
   assign rx_pop   = re && (addr == 3'd1);
   assign blen_wr  = we && (addr == 3'd2);
   assign cmd_wr   = we && (addr == 3'd3);
   assign flags_wr = we && (addr == 3'd5);
   assign cmd      = wdata[1:0];

   assign busy     = (state != IDLE);
   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign cs_act   = (state == SETUP) || (state == NEXT) || (state == SHIFT);
   assign mosi     = (state == SHIFT) & shifter[DATA_W-1];
   assign flags    = {tx_count, rx_count, cmd_err, rx_udf, tx_ovf, rx_empty, tx_full};

   spi_block_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .din(wdata), .pop(tx_pop),
      .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   spi_block_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift), .pop(rx_pop),
      .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   always_comb begin
      for (int i = 0; i < NUM_CS; i++) begin
         cs_n[i] = !(cs_act && (chip == CS_W'(i)));
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         3'd1:    rdata = rx_empty ? '0 : rx_head;
         3'd2:    rdata = DATA_W'(blen);
         3'd4:    rdata = DATA_W'(busy);
         3'd5:    rdata = DATA_W'(flags);
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blen    <= BLEN_W'(512);
         tx_ovf  <= 1'b0;
         rx_udf  <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         if (blen_wr) blen <= wdata[BLEN_W-1:0];
         // Clear first so a new error in the same cycle still sticks.
         if (flags_wr) begin
            tx_ovf  <= 1'b0;
            rx_udf  <= 1'b0;
            cmd_err <= 1'b0;
         end
         if (tx_push && tx_full && !tx_pop)  tx_ovf  <= 1'b1;
         if (rx_pop && rx_empty)              rx_udf  <= 1'b1;
         if (cmd_wr && busy && (cmd != 2'd3)) cmd_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mode     <= 1'b0;
         chip     <= '0;
         wcount   <= '0;
         shifter  <= '0;
         rx_shift <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         sclk     <= 1'b0;
      end else begin
         state    <= state_n;
         mode     <= mode_n;
         chip     <= chip_n;
         wcount   <= wcount_n;
         shifter  <= shifter_n;
         rx_shift <= rx_shift_n;
         bit_cnt  <= bit_n;
         div_cnt  <= div_n;
         sclk     <= sclk_n;
      end
   end

   always_comb begin
      state_n    = state;
      mode_n     = mode;
      chip_n     = chip;
      wcount_n   = wcount;
      shifter_n  = shifter;
      rx_shift_n = rx_shift;
      bit_n      = bit_cnt;
      div_n      = div_cnt;
      sclk_n     = sclk;
      tx_pop     = 1'b0;
      rx_push    = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_wr && ((cmd == 2'd1) || (cmd == 2'd2))) begin
               mode_n   = (cmd == 2'd2);
               chip_n   = wdata[8 +: CS_W];
               wcount_n = blen;
               div_n    = '0;
               sclk_n   = 1'b0;
               state_n  = (blen == '0) ? DONE : SETUP;
            end
         end
         SETUP: begin
            div_n = div_cnt + 1'b1;
            if (div_last) begin
               div_n   = '0;
               state_n = NEXT;
            end
         end
         NEXT: begin
            div_n = '0;
            bit_n = '0;
            if (!mode && !tx_empty) begin
               tx_pop    = 1'b1;
               shifter_n = tx_head;
               state_n   = SHIFT;
            end else if (mode && !rx_full) begin
               shifter_n = '1;   // read blocks drive all ones on mosi
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            div_n = div_cnt + 1'b1;
            if (div_last) begin
               div_n = '0;
               if (!sclk) begin
                  sclk_n     = 1'b1;
                  rx_shift_n = {rx_shift[DATA_W-2:0], miso};
               end else begin
                  sclk_n    = 1'b0;
                  shifter_n = {shifter[DATA_W-2:0], mode};
                  bit_n     = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                     // rx_shift already holds all DATA_W bits after the last rising edge.
                     rx_push  = mode;
                     bit_n    = '0;
                     wcount_n = wcount - 1'b1;
                     state_n  = (wcount == BLEN_W'(1)) ? DONE : NEXT;
                  end
               end
            end
         end
         DONE: begin
            div_n = div_cnt + 1'b1;
            if (div_last) begin
               div_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Abort drops the partial word but leaves both FIFOs untouched.
      if (cmd_wr && (cmd == 2'd3) && busy) begin
         state_n = IDLE;
         sclk_n  = 1'b0;
         div_n   = '0;
         bit_n   = '0;
         tx_pop  = 1'b0;
         rx_push = 1'b0;
      end
   end
endmodule
